// File: rtl/memory_bus_bridge.sv
// Bridges the controller's single-access memory handshake onto a request/grant/response bus.
// One access in flight at a time; hung or erroring bus accesses complete with memory_fault.
module memory_bus_bridge #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int COUNTER_WIDTH  = 8
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        memory_enable,
    input  logic        memory_command,
    input  logic [31:0] memory_address,
    input  logic [31:0] memory_write_data,
    input  logic [3:0]  memory_byte_enable,
    output logic        memory_ready,
    output logic        memory_valid,
    output logic [31:0] memory_read_data,
    output logic        memory_fault,

    output logic        bus_request,
    output logic        bus_write,
    output logic [31:0] bus_address,
    output logic [31:0] bus_write_data,
    output logic [3:0]  bus_byte_enable,
    input  logic        bus_grant,
    input  logic        bus_response_valid,
    input  logic [31:0] bus_read_data,
    input  logic        bus_error
);

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        WAIT_RESPONSE,
        RESPOND
    } state_t;

    localparam logic [COUNTER_WIDTH+1:0] TIMEOUT_LIMIT = (COUNTER_WIDTH+2)'(TIMEOUT_CYCLES);

    state_t                   state_reg;
    logic [COUNTER_WIDTH-1:0] timeout_count_reg;

    logic                     memory_valid_reg;
    logic [31:0]              memory_read_data_reg;
    logic                     memory_fault_reg;

    logic                     bus_request_reg;
    logic                     bus_write_reg;
    logic [31:0]              bus_address_reg;
    logic [31:0]              bus_write_data_reg;
    logic [3:0]               bus_byte_enable_reg;

    logic [3:0]               byte_enable_next;
    logic [COUNTER_WIDTH+1:0] valid_cycle_if_abort;
    logic                     timeout_hit;

    // Reads always present a full-word lane mask on the bus.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign byte_enable_next[gi] = memory_command ? memory_byte_enable[gi] : 1'b1;
        end
    endgenerate

    // The counter holds (cycles since acceptance - 1); giving up now raises memory_valid
    // two counts later, which must land exactly TIMEOUT_CYCLES after acceptance.
    always_comb begin
        valid_cycle_if_abort = {2'b00, timeout_count_reg} + (COUNTER_WIDTH+2)'(2);
        timeout_hit          = (TIMEOUT_CYCLES != 0) && (valid_cycle_if_abort == TIMEOUT_LIMIT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg            <= IDLE;
            timeout_count_reg    <= '0;
            memory_valid_reg     <= 1'b0;
            memory_read_data_reg <= 32'h0;
            memory_fault_reg     <= 1'b0;
            bus_request_reg      <= 1'b0;
            bus_write_reg        <= 1'b0;
            bus_address_reg      <= 32'h0;
            bus_write_data_reg   <= 32'h0;
            bus_byte_enable_reg  <= 4'h0;
        end else begin
            memory_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (memory_enable) begin
                        bus_write_reg       <= memory_command;
                        bus_address_reg     <= memory_address;
                        bus_write_data_reg  <= memory_write_data;
                        bus_byte_enable_reg <= byte_enable_next;
                        bus_request_reg     <= 1'b1;
                        timeout_count_reg   <= '0;
                        state_reg           <= REQUEST;
                    end
                end

                REQUEST: begin
                    timeout_count_reg <= timeout_count_reg + 1'b1;
                    if (bus_grant && bus_response_valid) begin
                        bus_request_reg      <= 1'b0;
                        memory_valid_reg     <= 1'b1;
                        memory_read_data_reg <= bus_write_reg ? 32'h0 : bus_read_data;
                        memory_fault_reg     <= bus_error;
                        state_reg            <= RESPOND;
                    end else if (timeout_hit) begin
                        bus_request_reg      <= 1'b0;
                        memory_valid_reg     <= 1'b1;
                        memory_read_data_reg <= 32'h0;
                        memory_fault_reg     <= 1'b1;
                        state_reg            <= RESPOND;
                    end else if (bus_grant) begin
                        bus_request_reg <= 1'b0;
                        state_reg       <= WAIT_RESPONSE;
                    end
                end

                WAIT_RESPONSE: begin
                    timeout_count_reg <= timeout_count_reg + 1'b1;
                    if (bus_response_valid) begin
                        memory_valid_reg     <= 1'b1;
                        memory_read_data_reg <= bus_write_reg ? 32'h0 : bus_read_data;
                        memory_fault_reg     <= bus_error;
                        state_reg            <= RESPOND;
                    end else if (timeout_hit) begin
                        memory_valid_reg     <= 1'b1;
                        memory_read_data_reg <= 32'h0;
                        memory_fault_reg     <= 1'b1;
                        state_reg            <= RESPOND;
                    end
                end

                RESPOND: begin
                    state_reg <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign memory_ready     = (state_reg == IDLE);
    assign memory_valid     = memory_valid_reg;
    assign memory_read_data = memory_read_data_reg;
    assign memory_fault     = memory_fault_reg;

    assign bus_request      = bus_request_reg;
    assign bus_write        = bus_write_reg;
    assign bus_address      = bus_address_reg;
    assign bus_write_data   = bus_write_data_reg;
    assign bus_byte_enable  = bus_byte_enable_reg;

endmodule
